// File: rtl/fp_add_round_pack.sv
// Round-and-pack stage for the FP adder: adjusts the exponent, rounds, clamps and packs an IEEE-754 single result.
// Two registered stages with valid/ready on both sides. Define ROUND_MODE_EN to add the rnd_mode input (RNE/RTZ/RUP/RDN).
module fp_add_round_pack #(
  parameter int EXP_W    = 8,
  parameter int MAN_W    = 24,
  parameter int BIAS_MAX = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign_in,
  input  logic [EXP_W-1:0]       exp_in,
  input  logic [4:0]             final_shift_left,
  input  logic [MAN_W-1:0]       correct_sum_shifted,
  input  logic                   guard_in,
  input  logic                   sticky_in,
  input  logic [1:0]             special_in,
`ifdef ROUND_MODE_EN
  input  logic [1:0]             rnd_mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inx
);

  localparam int XW = EXP_W + 2;
  localparam int RW = EXP_W + MAN_W;
  localparam logic signed [XW-1:0] C_EMAX = BIAS_MAX[XW-1:0];
  localparam logic [EXP_W-1:0]     C_EALL = BIAS_MAX[EXP_W-1:0];
  localparam logic [EXP_W-1:0]     C_EFIN = C_EALL - 1'b1;

  // Stage 1 state
  logic                    r1_valid, r1_sign, r1_guard, r1_sticky, r1_zero;
  logic signed [XW-1:0]    r1_exp;
  logic [MAN_W-1:0]        r1_man;
  logic [1:0]              r1_special;
`ifdef ROUND_MODE_EN
  logic [1:0]              r1_rnd;
`endif

  // Stage 2 state
  logic                    r2_valid, r2_ovf, r2_unf, r2_inx;
  logic [RW-1:0]           r2_result;

  logic                    w_s1_adv, w_push;
  logic signed [XW-1:0]    w_exp_adj, w_exp_r;
  logic                    w_inc, w_inexact, w_c23, w_carry, w_sat;
  logic [MAN_W-2:0]        w_frac_r, w_frac;
  logic [RW-1:0]           w_res;
  logic                    w_ovf, w_unf, w_inx;

  assign w_s1_adv = !r2_valid || out_ready;
  assign in_ready = !r1_valid || w_s1_adv;
  assign w_push   = in_valid && in_ready;

  assign w_exp_adj = $signed({2'b00, exp_in}) - $signed({{(XW-5){1'b0}}, final_shift_left});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid   <= 1'b0;
      r1_sign    <= 1'b0;
      r1_guard   <= 1'b0;
      r1_sticky  <= 1'b0;
      r1_zero    <= 1'b0;
      r1_exp     <= '0;
      r1_man     <= '0;
      r1_special <= 2'b00;
`ifdef ROUND_MODE_EN
      r1_rnd     <= 2'b00;
`endif
    end else if (in_ready) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sign    <= sign_in;
        r1_guard   <= guard_in;
        r1_sticky  <= sticky_in;
        r1_zero    <= (correct_sum_shifted == '0);
        r1_exp     <= w_exp_adj;
        r1_man     <= correct_sum_shifted;
        r1_special <= special_in;
`ifdef ROUND_MODE_EN
        r1_rnd     <= rnd_mode;
`endif
      end
    end
  end

  assign w_inexact = r1_guard | r1_sticky;

`ifdef ROUND_MODE_EN
  always_comb begin
    w_inc = 1'b0;
    w_sat = 1'b0;
    case (r1_rnd)
      2'b00: w_inc = r1_guard & (r1_sticky | r1_man[0]);
      2'b01: begin w_inc = 1'b0;                   w_sat = 1'b1;     end
      2'b10: begin w_inc = !r1_sign & w_inexact;   w_sat = r1_sign;  end
      default: begin w_inc = r1_sign & w_inexact;  w_sat = !r1_sign; end
    endcase
  end
`else
  assign w_inc = r1_guard & (r1_sticky | r1_man[0]);
  assign w_sat = 1'b0;
`endif

  // Carry out of the full mantissa only happens when the hidden bit is set and the fraction is all ones.
  assign {w_c23, w_frac_r} = {1'b0, r1_man[MAN_W-2:0]} + {{(MAN_W-1){1'b0}}, w_inc};
  assign w_carry = w_c23 & r1_man[MAN_W-1];
  assign w_frac  = w_carry ? '0 : w_frac_r;
  assign w_exp_r = r1_exp + $signed({{(XW-1){1'b0}}, w_carry});

  always_comb begin
    w_res = {r1_sign, r1_exp[EXP_W-1:0], w_frac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    w_inx = w_inexact;
    if (r1_special[1]) begin
      w_res = {1'b0, C_EALL, 1'b1, {(MAN_W-2){1'b0}}};
      w_inx = 1'b0;
    end else if (r1_special[0]) begin
      w_res = {r1_sign, C_EALL, {(MAN_W-1){1'b0}}};
      w_inx = 1'b0;
    end else if (r1_zero && !w_inexact) begin
      w_res = '0;
      w_inx = 1'b0;
    end else if (r1_exp <= 0) begin
      w_res = {r1_sign, {(RW-1){1'b0}}};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_r >= C_EMAX) begin
      w_res = w_sat ? {r1_sign, C_EFIN, {(MAN_W-1){1'b1}}}
                    : {r1_sign, C_EALL, {(MAN_W-1){1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else begin
      w_res = {r1_sign, w_exp_r[EXP_W-1:0], w_frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid  <= 1'b0;
      r2_result <= '0;
      r2_ovf    <= 1'b0;
      r2_unf    <= 1'b0;
      r2_inx    <= 1'b0;
    end else if (w_s1_adv) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_result <= w_res;
        r2_ovf    <= w_ovf;
        r2_unf    <= w_unf;
        r2_inx    <= w_inx;
      end
    end
  end

  assign out_valid = r2_valid;
  assign result    = r2_result;
  assign flag_ovf  = r2_ovf;
  assign flag_unf  = r2_unf;
  assign flag_inx  = r2_inx;

endmodule

// File: doc/fp_add_round_pack.md
Name: fp_add_round_pack

Overview:
- Stage directly downstream of the adder's LZA/normalise-shift stage; consumes its 24-bit normalised mantissa and 5-bit left-shift count.
- Adjusts the exponent, rounds, detects overflow/underflow and packs an IEEE-754 single-precision result.
- Two-stage registered pipeline with valid/ready handshake on both sides, so it can sit between the adder datapath and the FPU result bus.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 24, mantissa width including hidden bit.
- BIAS_MAX, 255, all-ones exponent code (inf/NaN).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept.
- sign_in  input  1  result sign from the adder.
- exp_in  input  8  pre-normalisation exponent (larger operand exponent, +1 already applied on carry-out).
- final_shift_left  input  5  total left shift from the LZA stage.
- correct_sum_shifted  input  24  normalised mantissa; bit 23 = hidden bit, or all zero.
- guard_in  input  1  first bit below the mantissa LSB.
- sticky_in  input  1  OR of all lower bits.
- special_in  input  2  00 normal, 01 inf, 10 NaN, 11 reserved (treated as NaN).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- result  output  32  packed {sign, exp, frac[22:0]}.
- flag_ovf  output  1  overflow.
- flag_unf  output  1  underflow, flushed to zero.
- flag_inx  output  1  inexact.

Behaviour:
- Reset: out_valid=0, result=0, all flags=0, both stage valid bits=0, in_ready=1.
- Handshake:
  - Transfer when valid&&ready on either side.
  - in_ready = !s1_valid || s1_advance; s1_advance = !s2_valid || out_ready.
  - Latency is exactly 2 cycles with no back-pressure; full throughput of 1 per cycle.
  - Under stall (out_ready=0), result and flags hold stable while out_valid=1.
- Stage 1 (register):
  - exp_adj = {2'b0,exp_in} − final_shift_left, computed as 10-bit signed.
  - Captures mantissa, guard, sticky, sign and special.
  - zero_flag = (correct_sum_shifted==0).
- Stage 2 (register), default round-to-nearest-even:
  - inc = guard & (sticky | man[0]).
  - man_r = man + inc (25 bits). On carry-out, mantissa = 0x800000 and exp_adj+1.
  - inexact = guard|sticky.
- Priority, evaluated in stage 2:
  1. special NaN → 0x7FC00000, no flags.
  2. special inf → {sign,8'hFF,23'b0}, no flags.
  3. zero_flag & !inexact → +0 (0x00000000), no flags.
  4. exp_adj ≤ 0 → {sign,31'b0}, flag_unf=1, flag_inx=1.
  5. exp_adj ≥ 255 after rounding → {sign,8'hFF,23'b0}, flag_ovf=1, flag_inx=1.
  6. Otherwise → {sign, exp_adj[7:0], man_r[22:0]}, flag_inx=inexact.
- Boundaries:
  - exp_adj=254 with rounding carry → overflow.
  - exp_adj=1 stays normal.
  - final_shift_left > exp_in → underflow.
  - Simultaneous push and pop while full is allowed with no bubble.
- Reset mid-operation clears both stages immediately; in-flight data is dropped and out_valid falls asynchronously.

Optional Feature:
- Macro ROUND_MODE_EN.
- When defined:
  - Adds input rnd_mode[1:0], sampled with in_valid and carried through stage 1.
  - Encodings: 00 RNE; 01 RTZ (inc=0); 10 RUP (inc=!sign&(guard|sticky)); 11 RDN (inc=sign&(guard|sticky)).
  - On overflow, RTZ, and RUP/RDN toward the opposite sign, return max finite {sign,8'hFE,23'h7FFFFF} instead of inf.
- When undefined: port absent, RNE fixed, behaviour exactly as above.

Test Plan:
- exp_in=127, shl=0, mant=0x800000, g=0, s=0 → 2 cycles later result=0x3F800000, flags 0.
- exp_in=130, shl=3, mant=0xC00000, sign=1 → result=0xBFC00000 (−1.5).
- mant=0xFFFFFF, g=1, s=0, exp_in=127, shl=0 → tie, odd LSB rounds up with carry → 0x40000000, flag_inx=1.
- exp_in=254, mant=0xFFFFFF, g=1 → 0x7F800000, flag_ovf=1, flag_inx=1. Repeat with ROUND_MODE_EN and rnd_mode=01 → 0x7F7FFFFF.
- exp_in=3, shl=5 → 0x00000000 or 0x80000000 per sign, flag_unf=1. mant=0, g=s=0 → 0x00000000, no flags.
- Back-to-back 4 inputs with out_ready low for cycles 3–5 → in_ready=0 once both stages are full; outputs held and delivered in order, none lost or duplicated. Assert rst mid-stream → out_valid=0 immediately.
